// File: rtl/riscv_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state encodings for the memory slave.
package riscv_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE,
    W_HAVE_ADDR,
    W_HAVE_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/sram_1r1w.sv
// Word-organised SRAM: one synchronous read port, one byte-enabled write port.
// Reads return the contents before a same-cycle write; the array itself is never reset.
module sram_1r1w #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [31:0]   rdata_o,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [3:0]    wstrb_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  // Only the output register is reset so rdata reads as zero out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite memory slave: independent write (AW/W/B) and read (AR/R) FSMs over sram_1r1w.
// Define AXI_MEM_DECERR_EN to answer out-of-range addresses with DECERR instead of wrapping.
module axi_lite_mem_slave
  import riscv_axi_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready
);

  localparam int IW = $clog2(DEPTH_WORDS);
`ifdef AXI_MEM_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return DECERR_EN && ((a >> (IW + 2)) != '0);
  endfunction

  wstate_e           w_q, w_d;
  rstate_e           r_q, r_d;
  logic              rdy_q;
  logic              rdy;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              rerr_q, rerr_d;

  logic              commit;
  logic [ADDR_W-1:0] cm_addr;
  logic [31:0]       cm_data;
  logic [3:0]        cm_strb;
  logic              we, re;
  logic [31:0]       sram_rdata;

  // Ready drops combinationally with reset so nothing handshakes in a reset cycle.
  assign rdy = rdy_q & s_axi_aresetn;

  always_comb begin
    w_d      = w_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    bresp_d  = bresp_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    commit  = 1'b0;
    cm_addr = s_axi_awaddr;
    cm_data = s_axi_wdata;
    cm_strb = s_axi_wstrb;
    case (w_q)
      W_IDLE: begin
        s_axi_awready = rdy;
        s_axi_wready  = rdy;
        if (rdy && s_axi_awvalid && s_axi_wvalid) begin
          commit = 1'b1;
        end else if (rdy && s_axi_awvalid) begin
          awaddr_d = s_axi_awaddr;
          w_d      = W_HAVE_ADDR;
        end else if (rdy && s_axi_wvalid) begin
          wdata_d = s_axi_wdata;
          wstrb_d = s_axi_wstrb;
          w_d     = W_HAVE_DATA;
        end
      end
      W_HAVE_ADDR: begin
        s_axi_wready = rdy;
        cm_addr      = awaddr_q;
        commit       = rdy && s_axi_wvalid;
      end
      W_HAVE_DATA: begin
        s_axi_awready = rdy;
        cm_data       = wdata_q;
        cm_strb       = wstrb_q;
        commit        = rdy && s_axi_awvalid;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_d = W_IDLE;
      end
      default: w_d = W_IDLE;
    endcase
    if (commit) begin
      bresp_d = addr_bad(cm_addr) ? RESP_DECERR : RESP_OKAY;
      w_d     = W_RESP;
    end
  end

  assign we          = commit && !addr_bad(cm_addr);
  assign s_axi_bresp = bresp_q;

  always_comb begin
    r_d    = r_q;
    rerr_d = rerr_q;
    re     = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_q)
      R_IDLE: begin
        s_axi_arready = rdy;
        if (rdy && s_axi_arvalid) begin
          re     = 1'b1;
          rerr_d = addr_bad(s_axi_araddr);
          r_d    = R_DATA;
        end
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_d = R_IDLE;
      end
      default: r_d = R_IDLE;
    endcase
  end

  assign s_axi_rresp = rerr_q ? RESP_DECERR : RESP_OKAY;
  assign s_axi_rdata = rerr_q ? 32'h0 : sram_rdata;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_q      <= W_IDLE;
      r_q      <= R_IDLE;
      rdy_q    <= 1'b0;
      awaddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rerr_q   <= 1'b0;
    end else begin
      w_q      <= w_d;
      r_q      <= r_d;
      rdy_q    <= 1'b1;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      bresp_q  <= bresp_d;
      rerr_q   <= rerr_d;
    end
  end

  sram_1r1w #(.DEPTH(DEPTH_WORDS), .AW(IW)) u_sram (
    .clk_i   (s_axi_aclk),
    .rst_ni  (s_axi_aresetn),
    .re_i    (re),
    .raddr_i (s_axi_araddr[IW+1:2]),
    .rdata_o (sram_rdata),
    .we_i    (we),
    .waddr_i (cm_addr[IW+1:2]),
    .wdata_i (cm_data),
    .wstrb_i (cm_strb)
  );

endmodule
